// File: rtl/gsm_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gsm_sched_pkg
// Brief    : Shared types and default geometry for the GSM FIR phase scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package gsm_sched_pkg;

    localparam int c_NPHASE   = 4;
    localparam int c_NMULT    = 13;
    localparam int c_NTAP     = 51;
    localparam int c_MULT_LAT = 2;
    localparam int c_PHASE_W  = $clog2(c_NPHASE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } sched_state_t;

endpackage : gsm_sched_pkg
`default_nettype wire

// File: rtl/gsm_sched_dly.sv
`default_nettype none
// ============================================================================
// Module   : gsm_sched_dly
// Brief    : DEPTH-stage shift register with synchronous clear; aligns the
//            lane valid/first/last flags with the multiplier product.
// Revision : 1.0 - initial release
// ============================================================================
module gsm_sched_dly
    import gsm_sched_pkg::*;
#(
    parameter int DEPTH = c_MULT_LAT,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH*WIDTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst || i_clr) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= i_d;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (rst || i_clr) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[(DEPTH-1)*WIDTH-1:0], i_d};
                end
            end
        end
    endgenerate

    assign o_q = r_sr[DEPTH*WIDTH-1 -: WIDTH];

endmodule : gsm_sched_dly
`default_nettype wire

// File: rtl/gsm_mult_phase_sched.sv
`default_nettype none
// ============================================================================
// Module   : gsm_mult_phase_sched
// Brief    : Phase scheduler for the time-shared-multiplier GSM FIR; tracks
//            sam_clk_en, drives mux/accumulator controls, recovers from bad
//            strobe timing. Define GSM_SCHED_STATS_EN for the error counter.
// Revision : 1.0 - initial release
// ============================================================================
module gsm_mult_phase_sched
    import gsm_sched_pkg::*;
#(
    parameter int NPHASE   = c_NPHASE,
    parameter int NMULT    = c_NMULT,
    parameter int NTAP     = c_NTAP,
    parameter int MULT_LAT = c_MULT_LAT
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      sam_clk_en,
    output logic [$clog2(NPHASE)-1:0] phase,
    output logic                      ctr_mask,
    output logic                      acc_first,
    output logic                      acc_en,
    output logic                      y_load,
    output logic                      locked,
    output logic                      sync_err,
    output logic [15:0]               sync_err_cnt
);

    localparam int              c_PW      = $clog2(NPHASE);
    localparam logic [c_PW-1:0] c_PH_LAST = c_PW'(NPHASE - 1);

    sched_state_t    r_state;
    sched_state_t    w_state_nxt;
    logic [c_PW-1:0] r_phase;
    logic [c_PW-1:0] w_phase_nxt;
    logic            r_sync_err;
    logic            r_strobe_q;
    logic            w_early;
    logic            w_late;
    logic            w_lane_valid;
    logic [2:0]      w_dly_d;
    logic [2:0]      w_dly_q;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_phase    <= c_PH_LAST;
            r_sync_err <= 1'b0;
            r_strobe_q <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_sync_err <= w_early | w_late;
            r_strobe_q <= sam_clk_en;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_early     = 1'b0;
        w_late      = 1'b0;
        w_phase_nxt = r_phase;
        case (r_state)
            S_IDLE: begin
                if (sam_clk_en) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (sam_clk_en) begin
                    w_early = (r_phase != c_PH_LAST);
                end else if (r_phase == c_PH_LAST) begin
                    w_late      = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (sam_clk_en) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A strobe always realigns the phase, whatever the state.
        if (sam_clk_en) begin
            w_phase_nxt = '0;
        end else if (r_state == S_RUN && r_phase != c_PH_LAST) begin
            w_phase_nxt = r_phase + c_PW'(1);
        end
    end

    assign w_lane_valid = (r_state == S_RUN) || r_strobe_q;

    assign w_dly_d[2] = w_lane_valid;
    assign w_dly_d[1] = w_lane_valid && (r_phase == '0);
    assign w_dly_d[0] = w_lane_valid && (r_phase == c_PH_LAST) && !w_early;

    // An early strobe abandons the partial sum still travelling to the accumulators.
    gsm_sched_dly #(
        .DEPTH (MULT_LAT),
        .WIDTH (3)
    ) u_dly (
        .clk   (sys_clk),
        .rst   (reset),
        .i_clr (w_early),
        .i_d   (w_dly_d),
        .o_q   (w_dly_q)
    );

    assign phase     = r_phase;
    assign ctr_mask  = (((NMULT - 1) * NPHASE) + int'(r_phase)) >= NTAP;
    assign acc_en    = w_dly_q[2];
    assign acc_first = w_dly_q[1];
    assign y_load    = w_dly_q[0];
    assign locked    = (r_state == S_RUN);
    assign sync_err  = r_sync_err;

`ifdef GSM_SCHED_STATS_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_err_cnt <= 16'd0;
        end else if ((w_early || w_late) && r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign sync_err_cnt = r_err_cnt;
`else
    assign sync_err_cnt = 16'd0;
`endif

endmodule : gsm_mult_phase_sched
`default_nettype wire

// File: tb/tb_gsm_mult_phase_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_gsm_mult_phase_sched
// Brief    : Scoreboard bench for gsm_mult_phase_sched: directed and random
//            strobe timing against a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gsm_mult_phase_sched;
    import gsm_sched_pkg::*;

    logic                 sys_clk    = 1'b0;
    logic                 reset      = 1'b1;
    logic                 sam_clk_en = 1'b0;
    logic [c_PHASE_W-1:0] phase;
    logic                 ctr_mask;
    logic                 acc_first;
    logic                 acc_en;
    logic                 y_load;
    logic                 locked;
    logic                 sync_err;
    logic [15:0]          sync_err_cnt;

    gsm_mult_phase_sched #(
        .NPHASE   (c_NPHASE),
        .NMULT    (c_NMULT),
        .NTAP     (c_NTAP),
        .MULT_LAT (c_MULT_LAT)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .sam_clk_en   (sam_clk_en),
        .phase        (phase),
        .ctr_mask     (ctr_mask),
        .acc_first    (acc_first),
        .acc_en       (acc_en),
        .y_load       (y_load),
        .locked       (locked),
        .sync_err     (sync_err),
        .sync_err_cnt (sync_err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int cyc;
        int phase;
        bit locked;
        bit ctr_mask;
        bit sync_err;
        bit acc_en;
        bit acc_first;
        bit y_load;
        int cnt;
    } exp_t;

    // One lane cycle whose product is still on its way to the accumulators.
    typedef struct {
        int c;
        bit first;
        bit last;
    } ent_t;

    exp_t exp_q[$];
    ent_t ent_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   seen  = 1'b0;
    int   last_strobe = 0;
    int   m_cnt = 0;

    function automatic bit exp_mask(input int ph);
        return (((c_NMULT - 1) * c_NPHASE) + ph) >= c_NTAP;
    endfunction

    // Expected outputs for the cycle that begins at this edge, derived from
    // the time since the last strobe rather than from any state encoding.
    task automatic model_edge(input bit s, input bit r);
        exp_t e;
        ent_t en;
        int   gap;
        int   since;
        bit   early;
        bit   late;
        cyc = cyc + 1;
        while (ent_q.size() > 0 && ent_q[0].c + c_MULT_LAT < cyc) void'(ent_q.pop_front());
        e.sync_err = 1'b0;
        if (r) begin
            seen  = 1'b0;
            m_cnt = 0;
            ent_q.delete();
        end else begin
            gap   = cyc - last_strobe;
            early = s && seen && (gap < c_NPHASE);
            late  = !s && seen && (gap == c_NPHASE);
            e.sync_err = early || late;
            if (early) ent_q.delete();
            if (s) begin
                seen        = 1'b1;
                last_strobe = cyc;
            end
`ifdef GSM_SCHED_STATS_EN
            if (e.sync_err && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
        end
        since      = cyc - last_strobe;
        e.cyc      = cyc;
        e.phase    = (seen && since < c_NPHASE - 1) ? since : c_NPHASE - 1;
        e.locked   = seen && (since < c_NPHASE);
        e.ctr_mask = exp_mask(e.phase);
        e.acc_en    = 1'b0;
        e.acc_first = 1'b0;
        e.y_load    = 1'b0;
        if (ent_q.size() > 0 && ent_q[0].c + c_MULT_LAT == cyc) begin
            en          = ent_q.pop_front();
            e.acc_en    = 1'b1;
            e.acc_first = en.first;
            e.y_load    = en.last;
        end
        if (e.locked) begin
            en.c     = cyc;
            en.first = (e.phase == 0);
            en.last  = (e.phase == c_NPHASE - 1);
            ent_q.push_back(en);
        end
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic tick(input bit s, input bit r);
        @(negedge sys_clk);
        sam_clk_en = s;
        reset      = r;
        @(posedge sys_clk);
        model_edge(s, r);
    endtask

    task automatic send_samples(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0);
            for (int k = 1; k < c_NPHASE; k++) tick(1'b0, 1'b0);
        end
    endtask

    task automatic check(input string name, input int act, input int req, input int c);
        total = total + 1;
        if (act != req) begin
            bad = bad + 1;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("phase",        int'(phase),        e.phase,          e.cyc);
                check("ctr_mask",     int'(ctr_mask),     int'(e.ctr_mask), e.cyc);
                check("locked",       int'(locked),       int'(e.locked),   e.cyc);
                check("sync_err",     int'(sync_err),     int'(e.sync_err), e.cyc);
                check("acc_en",       int'(acc_en),       int'(e.acc_en),   e.cyc);
                check("acc_first",    int'(acc_first),    int'(e.acc_first), e.cyc);
                check("y_load",       int'(y_load),       int'(e.y_load),   e.cyc);
                check("sync_err_cnt", int'(sync_err_cnt), e.cnt,            e.cyc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int g;
        int sel;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        send_samples(6);

        // early strobe two cycles into a sample
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        send_samples(4);

        // late strobe: six-cycle gap
        tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        send_samples(4);

        // reset together with a strobe while in phase 2
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
        send_samples(3);

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      g = int'($urandom_range(1, 3));
            else if (sel == 1) g = int'($urandom_range(5, 8));
            else               g = c_NPHASE;
            if ($urandom_range(0, 49) == 0) tick(1'($urandom_range(0, 1)), 1'b1);
            tick(1'b1, 1'b0);
            for (int k = 1; k < g; k++) tick(1'b0, 1'b0);
        end

        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: %0d expected cycles unchecked, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gsm_mult_phase_sched
`default_nettype wire
